// File: rtl/gray_sync_decode.sv
// Resynchronises a Gray-coded count from a foreign clock domain, decodes it to binary,
// and reports the per-sample increment, a change qualifier and a sticky Gray-step error.
module gray_sync_decode #(
  parameter int unsigned IN_DATA_WIDTH = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_DATA_WIDTH-1:0] gray_in,
  input  logic                     clr_err,
  output logic [IN_DATA_WIDTH-1:0] gray_out,
  output logic [IN_DATA_WIDTH-1:0] binary_out,
  output logic [IN_DATA_WIDTH-1:0] delta_out,
  output logic                     change_pulse,
  output logic                     step_err
);

  localparam int unsigned W = IN_DATA_WIDTH;
  localparam int unsigned S = SYNC_STAGES;

  logic [W-1:0] sync_q [S];
  logic [W-1:0] sync_d [S];
  logic [W-1:0] gray_out_q, gray_out_d;
  logic [W-1:0] binary_out_q, binary_out_d;
  logic [W-1:0] delta_out_q, delta_out_d;
  logic         change_pulse_q, change_pulse_d;
  logic         step_err_q, step_err_d;

  logic [W-1:0] gs;
  logic [W-1:0] gs_bin;
  logic [W-1:0] step_diff;
  logic         multi_bit;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b        = '0;
    b[W-1]   = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pure flop chain: no logic between synchroniser stages.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < int'(S); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign gs        = sync_q[S-1];
  assign gs_bin    = g2b(gs);
  assign step_diff = gs ^ gray_out_q;
  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign multi_bit = |(step_diff & (step_diff - W'(1)));

  always_comb begin
    gray_out_d     = gs;
    binary_out_d   = gs_bin;
    delta_out_d    = gs_bin - binary_out_q;
    change_pulse_d = |step_diff;
    step_err_d     = step_err_q;
    // A new violation takes priority over a clear in the same cycle.
    if (multi_bit) begin
      step_err_d = 1'b1;
    end else if (clr_err) begin
      step_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(S); i++) begin
        sync_q[i] <= '0;
      end
      gray_out_q     <= '0;
      binary_out_q   <= '0;
      delta_out_q    <= '0;
      change_pulse_q <= 1'b0;
      step_err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(S); i++) begin
        sync_q[i] <= sync_d[i];
      end
      gray_out_q     <= gray_out_d;
      binary_out_q   <= binary_out_d;
      delta_out_q    <= delta_out_d;
      change_pulse_q <= change_pulse_d;
      step_err_q     <= step_err_d;
    end
  end

  assign gray_out     = gray_out_q;
  assign binary_out   = binary_out_q;
  assign delta_out    = delta_out_q;
  assign change_pulse = change_pulse_q;
  assign step_err     = step_err_q;

endmodule

// File: tb/tb_gray_sync_decode.sv
// Bench for gray_sync_decode: directed scenarios plus a randomized Gray walk,
// checked against a history-based reference model.
module tb_gray_sync_decode;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gray_in;
  logic         clr_err;
  logic [W-1:0] gray_out;
  logic [W-1:0] binary_out;
  logic [W-1:0] delta_out;
  logic         change_pulse;
  logic         step_err;

  int n_cmp = 0;
  int n_err = 0;

  // Input history: index 0 is the edge just taken, index k is k edges earlier.
  logic [W-1:0] hist_g [S+1];
  logic         hist_r [S+1];
  logic [W-1:0] ref_gray, ref_bin, ref_delta;
  logic         ref_chg, ref_err;

  gray_sync_decode #(.IN_DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .gray_in      (gray_in),
    .clr_err      (clr_err),
    .gray_out     (gray_out),
    .binary_out   (binary_out),
    .delta_out    (delta_out),
    .change_pulse (change_pulse),
    .step_err     (step_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_gray(input int unsigned v);
    return W'(v ^ (v >> 1));
  endfunction

  // Binary value is the XOR of the Gray code with all its right shifts.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b = '0;
    for (int k = 0; k < int'(W); k++) b ^= (g >> k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by one edge and compare all outputs.
  task automatic tick(input logic [W-1:0] g, input logic r, input logic c);
    logic [W-1:0] gs;
    logic [W-1:0] nb;
    gray_in = g;
    rst     = r;
    clr_err = c;
    @(posedge clk);
    for (int k = int'(S); k > 0; k--) begin
      hist_g[k] = hist_g[k-1];
      hist_r[k] = hist_r[k-1];
    end
    hist_g[0] = g;
    hist_r[0] = r;
    // Value reaching the output stage: sampled S edges ago, unless a reset intervened.
    gs = hist_g[S];
    for (int k = 1; k <= int'(S); k++) if (hist_r[k]) gs = '0;
    if (r) begin
      ref_gray = '0; ref_bin = '0; ref_delta = '0; ref_chg = 1'b0; ref_err = 1'b0;
    end else begin
      nb        = ref_g2b(gs);
      ref_delta = W'((int'(nb) - int'(ref_bin) + 16) % 16);
      ref_chg   = (gs != ref_gray);
      if ($countones(gs ^ ref_gray) > 1) ref_err = 1'b1;
      else if (c)                        ref_err = 1'b0;
      ref_gray  = gs;
      ref_bin   = nb;
    end
    #1;
    chk("gray_out",     gray_out,          ref_gray);
    chk("binary_out",   binary_out,        ref_bin);
    chk("delta_out",    delta_out,         ref_delta);
    chk("change_pulse", W'(change_pulse),  W'(ref_chg));
    chk("step_err",     W'(step_err),      W'(ref_err));
  endtask

  initial begin
    for (int k = 0; k <= int'(S); k++) begin
      hist_g[k] = '0;
      hist_r[k] = 1'b1;
    end
    ref_gray = '0; ref_bin = '0; ref_delta = '0; ref_chg = 1'b0; ref_err = 1'b0;
    gray_in = '0; rst = 1'b1; clr_err = 1'b0;

    // Reset with all-ones input, then release.
    repeat (3) tick(4'b1111, 1'b1, 1'b0);
    chk("rst_bin_zero", binary_out, 4'b0000);
    repeat (3) tick(4'b1111, 1'b0, 1'b0);
    chk("rel_bin",   binary_out,        4'b1010);
    chk("rel_delta", delta_out,         4'd10);
    chk("rel_chg",   W'(change_pulse),  4'd1);
    chk("rel_err",   W'(step_err),      4'd1);

    // Full count walk including wrap, from a clean reset.
    tick(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(to_gray(i % 16), 1'b0, 1'b0);
    chk("cnt_err", W'(step_err), 4'd0);
    chk("cnt_wrap_delta", delta_out, 4'd1);

    // Hold.
    repeat (10) tick(4'b0110, 1'b0, 1'b0);
    chk("hold_bin",   binary_out,       4'b0100);
    chk("hold_delta", delta_out,        4'd0);
    chk("hold_chg",   W'(change_pulse), 4'd0);

    // Jump by two bits from a settled zero.
    tick(4'b0000, 1'b1, 1'b0);
    repeat (5) tick(4'b0000, 1'b0, 1'b0);
    repeat (3) tick(4'b0011, 1'b0, 1'b0);
    chk("jump_bin",   binary_out,    4'b0010);
    chk("jump_delta", delta_out,     4'd2);
    chk("jump_err",   W'(step_err),  4'd1);
    repeat (4) tick(4'b0011, 1'b0, 1'b0);
    chk("jump_sticky", W'(step_err), 4'd1);

    // Clear coinciding with a new violation, then a clean clear.
    repeat (3) tick(4'b1100, 1'b0, 1'b1);
    chk("clr_vs_set", W'(step_err), 4'd1);
    tick(4'b1100, 1'b0, 1'b1);
    chk("clr_ok", W'(step_err), 4'd0);

    // Mid-stream reset while counting.
    tick(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(to_gray(i), 1'b0, 1'b0);
    chk("pre_mid_bin", binary_out, 4'd7);
    tick(to_gray(10), 1'b1, 1'b0);
    chk("mid_rst_bin", binary_out, 4'd0);
    for (int i = 11; i < 20; i++) tick(to_gray(i % 16), 1'b0, 1'b0);

    // Randomized Gray walk with occasional jumps, clears and resets.
    begin
      int unsigned cnt = 0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 9) == 0) cnt = $urandom_range(0, 15);
        else if ($urandom_range(0, 3) != 0) cnt = (cnt + 1) % 16;
        tick(to_gray(cnt), ($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
